// File: rtl/timing_pkt_pkg.sv
// Shared definitions for the 1 ms timing-packet generator: header constants,
// bus-width derived sizing helpers, FSM state encoding and the per-packet
// snapshot record that is the only source of header content.
package timing_pkt_pkg;

    localparam logic [15:0] TPID         = 16'h8100;
    localparam logic [15:0] ETHERTYPE    = 16'hAEFE;
    localparam logic [7:0]  ECPRI_REV    = 8'h10;
    localparam logic [7:0]  MSG_TYPE     = 8'h02;
    localparam logic [15:0] PAYLOAD_SIZE = 16'h0010;
    localparam logic [15:0] RTC_ID       = 16'h0003;
    localparam int          HDR_BYTES    = 40;

    // Number of bus beats needed to carry the header (10, 5 or 3).
    function automatic int beats_for(input int data_width);
        return (HDR_BYTES + data_width / 8 - 1) / (data_width / 8);
    endfunction

    // Width of the empty-byte count for a given bus width.
    function automatic int empty_w_for(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [47:0] da;
        logic [47:0] sa;
        logic [11:0] vid;
        logic [15:0] seq;
        logic [7:0]  flags;
        logic [15:0] frame;
        logic [15:0] slot;
    } snap_t;

endpackage

// File: rtl/timing_packet_gen_if.sv
// Arbiter handshake plus Avalon-ST source bundle of the timing-packet generator.
// master: generator side (drives request/eop and the stream, samples grant/ready).
// slave:  arbiter/sink side.
interface timing_packet_gen_if #(
    parameter int DATA_WIDTH = 64
);
    import timing_pkt_pkg::*;

    localparam int EMPTY_W = empty_w_for(DATA_WIDTH);

    logic [1:0]            packet_request;
    logic                  packet_grant;
    logic                  packet_eop;
    logic                  dout_ready;
    logic                  dout_valid;
    logic                  dout_sop;
    logic                  dout_eop;
    logic                  dout_error;
    logic [DATA_WIDTH-1:0] dout_data;
    logic [EMPTY_W-1:0]    dout_empty;

    modport master (
        output packet_request, packet_eop,
        output dout_valid, dout_sop, dout_eop, dout_error, dout_data, dout_empty,
        input  packet_grant, dout_ready
    );

    modport slave (
        input  packet_request, packet_eop,
        input  dout_valid, dout_sop, dout_eop, dout_error, dout_data, dout_empty,
        output packet_grant, dout_ready
    );

endinterface

// File: rtl/timing_pkt_status.sv
// Sticky fronthaul status flags plus saturating dl overflow counter.
// Latency: events visible on flags one cycle after the pulse.
// Backpressure: none; capture returns the current value and restarts accumulation.
// Ports: clk/rst_n; four status event pulses; capture clears; flags =
//        {dl_ovf_cnt[3:0], ul_ovf, dl_ovf, dl_unf, sync}.
module timing_pkt_status (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ul_overflow_in,
    input  logic       dl_overflow_in,
    input  logic       dl_underflow_in,
    input  logic       sync_status_in,
    input  logic       capture,
    output logic [7:0] flags
);

    logic       ul_q;
    logic       dl_q;
    logic       unf_q;
    logic       sync_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ul_q   <= 1'b0;
            dl_q   <= 1'b0;
            unf_q  <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else if (capture) begin
            // The owner takes the current value; an event arriving in the same
            // cycle starts the next accumulation instead of being dropped.
            ul_q   <= ul_overflow_in;
            dl_q   <= dl_overflow_in;
            unf_q  <= dl_underflow_in;
            sync_q <= sync_status_in;
            cnt_q  <= {3'b000, dl_overflow_in};
        end else begin
            ul_q   <= ul_q | ul_overflow_in;
            dl_q   <= dl_q | dl_overflow_in;
            unf_q  <= unf_q | dl_underflow_in;
            sync_q <= sync_q | sync_status_in;
            if (dl_overflow_in && cnt_q != 4'hF) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign flags = {cnt_q, ul_q, dl_q, unf_q, sync_q};

endmodule

// File: rtl/timing_packet_gen.sv
// 1 ms timing-packet source: snapshots indices/status per tick and streams a 40-byte Eth/VLAN/eCPRI header.
// Latency: request 3 cycles after irq rising edge (2-flop sync + edge detect + capture); data 1 cycle after grant.
// Backpressure: per-beat via dout_ready, outputs held while low; one trigger queued, further ones counted in missed_cnt.
// Ports: clk, rst_n, enable, irq_1ms; frame/slot/vlan/MAC inputs; status pulses; seq_id, missed_cnt;
//        bus carries packet_request/grant/eop and the Avalon-ST dout_* signals.
module timing_packet_gen
    import timing_pkt_pkg::*;
#(
    parameter int          DATA_WIDTH      = 64,
    parameter bit          DATA_BIG_ENDIAN = 1'b1,
    parameter int          LATENCY_ARB     = 2,      // must be below the beat count
    parameter logic [1:0]  REQ_PRIORITY    = 2'd3,
    parameter logic [2:0]  VLAN_PCP        = 3'd7,
    parameter logic [7:0]  SCS_CFG         = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        irq_1ms,
    input  logic [15:0] frame_index,
    input  logic [15:0] slot_index,
    input  logic [11:0] vlan_id,
    input  logic [31:0] dest_addr_l,
    input  logic [31:0] dest_addr_h,
    input  logic [31:0] sour_addr_l,
    input  logic [31:0] sour_addr_h,
    input  logic        ul_overflow_in,
    input  logic        dl_overflow_in,
    input  logic        dl_underflow_in,
    input  logic        sync_status_in,
    output logic [15:0] seq_id,
    output logic [7:0]  missed_cnt,
    timing_packet_gen_if.master bus
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BEATS     = beats_for(DATA_WIDTH);
    localparam int PAD_BYTES = BEATS * BYTES;
    localparam int EMPTY_W   = empty_w_for(DATA_WIDTH);
    localparam int BEAT_W    = 4;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0]  EARLY_BEAT = BEAT_W'(BEATS - 1 - LATENCY_ARB);
    localparam logic [EMPTY_W-1:0] EOP_EMPTY  = EMPTY_W'(PAD_BYTES - HDR_BYTES);

    // Only the low 16 bits of the *_addr_h words form the MAC.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dest_addr_h[31:16], sour_addr_h[31:16]};

    // Tick synchroniser and rising-edge detect.
    logic irq_s1, irq_s2, irq_s3;
    logic trig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {irq_s3, irq_s2, irq_s1} <= 3'b000;
        end else begin
            {irq_s3, irq_s2, irq_s1} <= {irq_s2, irq_s1, irq_1ms};
        end
    end

    assign trig = irq_s2 & ~irq_s3 & enable;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              pending_q;
    logic              req_q;
    logic [7:0]        missed_q;
    logic [15:0]       seq_q;
    snap_t             snap_q;
    logic              capture;
    logic              xfer, early_xfer, last_xfer;
    logic [7:0]        status_flags;

    timing_pkt_status u_status (
        .clk             (clk),
        .rst_n           (rst_n),
        .ul_overflow_in  (ul_overflow_in),
        .dl_overflow_in  (dl_overflow_in),
        .dl_underflow_in (dl_underflow_in),
        .sync_status_in  (sync_status_in),
        .capture         (capture),
        .flags           (status_flags)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig || pending_q) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.packet_grant) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                end
            end
            ST_SEND: begin
                if (bus.dout_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign xfer       = (state_q == ST_SEND) && bus.dout_ready;
    assign early_xfer = xfer && (beat_q == EARLY_BEAT);
    assign last_xfer  = xfer && (beat_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            pending_q <= 1'b0;
            req_q     <= 1'b0;
            missed_q  <= 8'd0;
            seq_q     <= 16'd0;
            snap_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;

            if (capture) begin
                // A tick landing while a queued one is consumed stays queued.
                pending_q <= pending_q & trig;
            end else if (trig && state_q != ST_IDLE) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (missed_q != 8'hFF) begin
                    missed_q <= missed_q + 8'd1;
                end
            end

            if (capture) begin
                req_q <= 1'b1;
            end else if (early_xfer) begin
                req_q <= 1'b0;
            end

            if (last_xfer) begin
                seq_q <= seq_q + 16'd1;
            end

            if (capture) begin
                snap_q.da    <= {dest_addr_h[15:0], dest_addr_l};
                snap_q.sa    <= {sour_addr_h[15:0], sour_addr_l};
                snap_q.vid   <= vlan_id;
                snap_q.seq   <= seq_q;
                snap_q.flags <= status_flags;
                snap_q.frame <= frame_index;
                snap_q.slot  <= slot_index;
            end
        end
    end

    // Header in wire order; bytes past HDR_BYTES are padding and stay zero.
    logic [7:0] hdr [PAD_BYTES];

    always_comb begin
        for (int i = 0; i < PAD_BYTES; i++) begin
            hdr[i] = 8'h00;
        end
        for (int i = 0; i < 6; i++) begin
            hdr[i]     = snap_q.da[47-8*i -: 8];
            hdr[6 + i] = snap_q.sa[47-8*i -: 8];
        end
        hdr[12] = TPID[15:8];
        hdr[13] = TPID[7:0];
        hdr[14] = {VLAN_PCP, 1'b0, snap_q.vid[11:8]};
        hdr[15] = snap_q.vid[7:0];
        hdr[16] = ETHERTYPE[15:8];
        hdr[17] = ETHERTYPE[7:0];
        hdr[18] = ECPRI_REV;
        hdr[19] = MSG_TYPE;
        hdr[20] = PAYLOAD_SIZE[15:8];
        hdr[21] = PAYLOAD_SIZE[7:0];
        hdr[22] = RTC_ID[15:8];
        hdr[23] = RTC_ID[7:0];
        hdr[24] = snap_q.seq[15:8];
        hdr[25] = snap_q.seq[7:0];
        hdr[27] = snap_q.flags;
        hdr[31] = SCS_CFG;
        hdr[32] = snap_q.frame[15:8];
        hdr[33] = snap_q.frame[7:0];
        hdr[34] = snap_q.slot[15:8];
        hdr[35] = snap_q.slot[7:0];
    end

    logic [DATA_WIDTH-1:0] beat_data;

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (DATA_BIG_ENDIAN) begin
                        beat_data[DATA_WIDTH-1-8*b -: 8] = hdr[k*BYTES + b];
                    end else begin
                        beat_data[8*b +: 8] = hdr[k*BYTES + b];
                    end
                end
            end
        end
    end

    logic sending;
    assign sending = (state_q == ST_SEND);

    // Request drops in the same cycle the early-release pulse fires.
    assign bus.packet_eop     = early_xfer;
    assign bus.packet_request = (req_q && !early_xfer) ? REQ_PRIORITY : 2'd0;
    assign bus.dout_valid     = sending;
    assign bus.dout_sop       = sending && (beat_q == '0);
    assign bus.dout_eop       = sending && (beat_q == LAST_BEAT);
    assign bus.dout_empty     = (sending && beat_q == LAST_BEAT) ? EOP_EMPTY : '0;
    assign bus.dout_error     = 1'b0;
    assign bus.dout_data      = sending ? beat_data : '0;

    assign seq_id     = seq_q;
    assign missed_cnt = missed_q;

endmodule

// File: tb/tb_timing_packet_gen.sv
module tb_timing_packet_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        irq;
    logic        irq2;
    logic [15:0] frame_index;
    logic [15:0] slot_index;
    logic [11:0] vlan_id;
    logic [31:0] dest_addr_l, dest_addr_h, sour_addr_l, sour_addr_h;
    logic        ul_ovf, dl_ovf, dl_unf, sync_st;
    logic [15:0] seq1, seq2;
    logic [7:0]  missed1, missed2;

    int checks = 0;
    int errors = 0;

    timing_packet_gen_if #(.DATA_WIDTH(64))  if1 ();
    timing_packet_gen_if #(.DATA_WIDTH(128)) if2 ();

    timing_packet_gen #(.DATA_WIDTH(64), .DATA_BIG_ENDIAN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .irq_1ms(irq),
        .frame_index(frame_index), .slot_index(slot_index), .vlan_id(vlan_id),
        .dest_addr_l(dest_addr_l), .dest_addr_h(dest_addr_h),
        .sour_addr_l(sour_addr_l), .sour_addr_h(sour_addr_h),
        .ul_overflow_in(ul_ovf), .dl_overflow_in(dl_ovf),
        .dl_underflow_in(dl_unf), .sync_status_in(sync_st),
        .seq_id(seq1), .missed_cnt(missed1), .bus(if1)
    );

    timing_packet_gen #(.DATA_WIDTH(128), .DATA_BIG_ENDIAN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .irq_1ms(irq2),
        .frame_index(frame_index), .slot_index(slot_index), .vlan_id(vlan_id),
        .dest_addr_l(dest_addr_l), .dest_addr_h(dest_addr_h),
        .sour_addr_l(sour_addr_l), .sour_addr_h(sour_addr_h),
        .ul_overflow_in(ul_ovf), .dl_overflow_in(dl_ovf),
        .dl_underflow_in(dl_unf), .sync_status_in(sync_st),
        .seq_id(seq2), .missed_cnt(missed2), .bus(if2)
    );

    // Second instance: always-ready sink, grant as soon as it requests.
    assign if2.packet_grant = (if2.packet_request != 2'd0);
    assign if2.dout_ready   = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic [63:0] dat;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        peop;
        logic [1:0]  req;
    } vec_t;

    vec_t         tbl [14];
    logic [127:0] tbl2 [3];

    task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (if1.packet_request != 2'd0) begin
                got = 1'b1;
                break;
            end
        end
        check("req_seen", 0, got, 1);
    endtask

    task automatic pulse_irq();
        irq = 1'b1;
        repeat (2) @(negedge clk);
        irq = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Grants, accepts the whole packet with ready high, reports beat count and beat 3.
    task automatic drain_packet(output int nbeats, output logic [63:0] b3);
        bit got;
        nbeats = 0;
        b3 = '0;
        wait_req(got);
        if (got) begin
            if1.packet_grant = 1'b1;
            @(negedge clk);
            if1.packet_grant = 1'b0;
            if1.dout_ready = 1'b1;
            for (int n = 0; n < 30; n++) begin
                #1;
                if (if1.dout_valid) begin
                    if (nbeats == 3) b3 = if1.dout_data;
                    nbeats++;
                    if (if1.dout_eop) break;
                end
                @(negedge clk);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_table(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if1.dout_ready = tbl[start+i].rdy;
            #1;
            check("valid", start+i, if1.dout_valid, tbl[start+i].vld);
            check("data",  start+i, if1.dout_data,  tbl[start+i].dat);
            check("sop",   start+i, if1.dout_sop,   tbl[start+i].sop);
            check("eop",   start+i, if1.dout_eop,   tbl[start+i].eop);
            check("empty", start+i, if1.dout_empty, tbl[start+i].empty);
            check("pkt_eop", start+i, if1.packet_eop, tbl[start+i].peop);
            check("request", start+i, if1.packet_request, tbl[start+i].req);
            check("error", start+i, if1.dout_error, 1'b0);
        end
    endtask

    initial begin
        bit          got;
        int          nb;
        logic [63:0] b3;

        // Packet with seq 0, flags 0: DA 0A0B0C0D0E0F, SA 111213141516, VID 123.
        tbl[0]  = '{1'b1, 1'b1, 64'h0A0B0C0D0E0F1112, 1'b1, 1'b0, 3'd0, 1'b0, 2'd3};
        tbl[1]  = '{1'b1, 1'b1, 64'h131415168100E123, 1'b0, 1'b0, 3'd0, 1'b0, 2'd3};
        tbl[2]  = '{1'b1, 1'b1, 64'hAEFE100200100003, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 1'b1, 64'h0000000000000001, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
        tbl[4]  = '{1'b1, 1'b1, 64'h1234567800000000, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 1'b0, 64'h0,                1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
        // Same header, seq 1, ready pattern 1,0,0,1,1,1,1.
        tbl[6]  = '{1'b1, 1'b1, 64'h0A0B0C0D0E0F1112, 1'b1, 1'b0, 3'd0, 1'b0, 2'd3};
        tbl[7]  = '{1'b0, 1'b1, 64'h131415168100E123, 1'b0, 1'b0, 3'd0, 1'b0, 2'd3};
        tbl[8]  = '{1'b0, 1'b1, 64'h131415168100E123, 1'b0, 1'b0, 3'd0, 1'b0, 2'd3};
        tbl[9]  = '{1'b1, 1'b1, 64'h131415168100E123, 1'b0, 1'b0, 3'd0, 1'b0, 2'd3};
        tbl[10] = '{1'b1, 1'b1, 64'hAEFE100200100003, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0};
        tbl[11] = '{1'b1, 1'b1, 64'h0001000000000001, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
        tbl[12] = '{1'b1, 1'b1, 64'h1234567800000000, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0};
        tbl[13] = '{1'b1, 1'b0, 64'h0,                1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
        // 128-bit little-endian beats: wire byte 0 in bits [7:0].
        tbl2[0] = 128'h23E10081161514131211_0F0E0D0C0B0A;
        tbl2[1] = 128'h0100000000000000_03001000_0210FEAE;
        tbl2[2] = 128'h0000000000000000_00000000_78563412;

        rst_n = 1'b0; enable = 1'b1; irq = 1'b0; irq2 = 1'b0;
        frame_index = 16'h1234; slot_index = 16'h5678; vlan_id = 12'h123;
        dest_addr_h = 32'hFFFF0A0B; dest_addr_l = 32'h0C0D0E0F;
        sour_addr_h = 32'hA5A51112; sour_addr_l = 32'h13141516;
        ul_ovf = 1'b0; dl_ovf = 1'b0; dl_unf = 1'b0; sync_st = 1'b0;
        if1.packet_grant = 1'b0; if1.dout_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 0, if1.dout_valid, 0);
        check("rst_req", 0, if1.packet_request, 0);
        check("rst_data", 0, if1.dout_data, 0);
        check("rst_sop", 0, if1.dout_sop, 0);
        check("rst_peop", 0, if1.packet_eop, 0);
        check("rst_seq", 0, seq1, 0);
        check("rst_missed", 0, missed1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 64-bit packet; input change after capture must not leak in.
        if1.dout_ready = 1'b1;
        irq = 1'b1;
        wait_req(got);
        if1.packet_grant = 1'b1;
        irq = 1'b0;
        @(negedge clk);
        if1.packet_grant = 1'b0;
        frame_index = 16'hBEEF;
        run_table(0, 6);
        frame_index = 16'h1234;
        check("t1_seq", 0, seq1, 1);

        // 128-bit little-endian instance.
        irq2 = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (if2.dout_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("t2_valid_seen", 0, got, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("t2_data", i, if2.dout_data, tbl2[i]);
            check("t2_sop", i, if2.dout_sop, (i == 0));
            check("t2_eop", i, if2.dout_eop, (i == 2));
            check("t2_empty", i, if2.dout_empty, (i == 2) ? 8 : 0);
        end
        irq2 = 1'b0;
        @(negedge clk);
        #1;
        check("t2_seq", 0, seq2, 1);
        check("t2_missed", 0, missed2, 0);

        // Disabled ticks are ignored.
        enable = 1'b0;
        irq = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("disabled_req", 0, if1.packet_request, 0);
        irq = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;

        // Backpressure pattern.
        irq = 1'b1;
        wait_req(got);
        if1.packet_grant = 1'b1;
        irq = 1'b0;
        @(negedge clk);
        if1.packet_grant = 1'b0;
        run_table(6, 8);
        check("t3_seq", 0, seq1, 2);

        // Busy triggers: one queued, one missed, back-to-back follow-up.
        irq = 1'b1;
        wait_req(got);
        if1.packet_grant = 1'b1;
        irq = 1'b0;
        @(negedge clk);
        if1.packet_grant = 1'b0;
        if1.dout_ready = 1'b0;
        pulse_irq();
        pulse_irq();
        repeat (3) @(negedge clk);
        #1;
        check("t4_missed", 0, missed1, 1);
        check("t4_hold_sop", 0, if1.dout_sop, 1);
        if1.dout_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (if1.dout_valid && if1.dout_eop) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("t4_eop_seen", 0, got, 1);
        @(negedge clk);
        #1;
        check("t4_idle_valid", 0, if1.dout_valid, 0);
        check("t4_idle_req", 0, if1.packet_request, 0);
        @(negedge clk);
        #1;
        check("t4_next_req", 0, if1.packet_request, 3);
        check("t4_seq_a", 0, seq1, 3);
        drain_packet(nb, b3);
        check("t4_beats", 0, nb, 5);
        check("t4_seq_b", 0, b3[63:48], 3);

        for (int i = 0; i < 300; i++) pulse_irq();
        #1;
        check("t4_missed_sat", 0, missed1, 255);
        drain_packet(nb, b3);
        check("t4_seq_c", 0, b3[63:48], 4);
        drain_packet(nb, b3);
        check("t4_seq_d", 0, b3[63:48], 5);
        check("t4_seq_out", 0, seq1, 6);

        // Sticky flags: 20 dl overflows, ul overflow during the capture cycle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dl_ovf = 1'b1;
            @(negedge clk);
            dl_ovf = 1'b0;
        end
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ul_ovf = 1'b1;
        @(negedge clk);
        ul_ovf = 1'b0;
        irq = 1'b0;
        #1;
        check("t5_capture_req", 0, if1.packet_request, 3);
        drain_packet(nb, b3);
        check("t5_flags_a", 0, b3[39:32], 8'hF4);
        check("t5_seq_a", 0, b3[63:48], 6);
        pulse_irq();
        drain_packet(nb, b3);
        check("t5_flags_b", 0, b3[39:32], 8'h08);
        check("t5_seq_b", 0, b3[63:48], 7);

        // Reset in the middle of a packet.
        irq = 1'b1;
        wait_req(got);
        if1.packet_grant = 1'b1;
        irq = 1'b0;
        @(negedge clk);
        if1.packet_grant = 1'b0;
        if1.dout_ready = 1'b0;
        @(negedge clk);
        #1;
        check("t6_pre_valid", 0, if1.dout_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 0, if1.dout_valid, 0);
        check("t6_rst_req", 0, if1.packet_request, 0);
        check("t6_rst_data", 0, if1.dout_data, 0);
        check("t6_rst_seq", 0, seq1, 0);
        check("t6_rst_missed", 0, missed1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        irq = 1'b1;
        drain_packet(nb, b3);
        irq = 1'b0;
        check("t6_beats", 0, nb, 5);
        check("t6_seq_pkt", 0, b3[63:48], 0);
        check("t6_seq_out", 0, seq1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
